// File: rtl/exu_seq.sv
// Execute-stage sequencer: captures one decoded op per handshake, drives the EXU operand
// registers, sequences single- or multi-cycle completion and holds the result for writeback.
module exu_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int MC_TIMEOUT = 80,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [5:0]            id_ctrl_i,
    input  logic                  id_mc_i,
    input  logic [DATA_WIDTH-1:0] id_rs1_i,
    input  logic [DATA_WIDTH-1:0] id_rs2_i,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [DATA_WIDTH-1:0] id_imme_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    output logic [5:0]            exu_ctrl_o,
    output logic [DATA_WIDTH-1:0] exu_rs1_o,
    output logic [DATA_WIDTH-1:0] exu_rs2_o,
    output logic [DATA_WIDTH-1:0] exu_pc_o,
    output logic [DATA_WIDTH-1:0] exu_imme_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  mc_start_o,
    output logic                  mc_kill_o,
    input  logic                  mc_done_i,
    input  logic [DATA_WIDTH-1:0] mc_result_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  retired_o
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MC, WB} state_t;

    state_t                  state_q;
    logic [5:0]              ctrl_q;
    logic [DATA_WIDTH-1:0]   rs1_q, rs2_q, pc_q, imme_q, wb_data_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [TW-1:0]           cnt_q;
    logic                    mc_start_q, mc_kill_q, wb_valid_q, err_q;
    logic [CNT_WIDTH-1:0]    retired_q;
    logic                    accept;

    assign id_ready_o = (state_q == IDLE) || ((state_q == WB) && wb_ready_i);
    assign accept     = id_valid_i && id_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            pc_q       <= '0;
            imme_q     <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            mc_start_q <= 1'b0;
            mc_kill_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            retired_q  <= '0;
        end else begin
            mc_start_q <= 1'b0;
            mc_kill_q  <= 1'b0;
            if (flush_i) begin
                // Redirect wins over everything; an in-flight multi-cycle op must be aborted
                if (state_q == MC) mc_kill_q <= 1'b1;
                state_q    <= IDLE;
                wb_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    EXEC: begin
                        wb_data_q  <= alu_result_i;
                        wb_valid_q <= 1'b1;
                        state_q    <= WB;
                    end
                    MC: begin
                        if (mc_done_i) begin
                            wb_data_q  <= mc_result_i;
                            wb_valid_q <= 1'b1;
                            state_q    <= WB;
                        end else if (cnt_q == CNT_LAST) begin
                            err_q      <= 1'b1;
                            wb_data_q  <= '0;
                            mc_kill_q  <= 1'b1;
                            wb_valid_q <= 1'b1;
                            state_q    <= WB;
                        end else begin
                            cnt_q <= cnt_q + TW'(1);
                        end
                    end
                    WB: begin
                        if (wb_ready_i) begin
                            retired_q  <= retired_q + CNT_WIDTH'(1);
                            wb_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // A new op overrides the WB->IDLE transition for back-to-back issue
                if (accept) begin
                    ctrl_q     <= id_ctrl_i;
                    rs1_q      <= id_rs1_i;
                    rs2_q      <= id_rs2_i;
                    pc_q       <= id_pc_i;
                    imme_q     <= id_imme_i;
                    rd_q       <= id_rd_i;
                    cnt_q      <= '0;
                    mc_start_q <= id_mc_i;
                    state_q    <= id_mc_i ? MC : EXEC;
                end
            end
        end
    end

    assign exu_ctrl_o = ctrl_q;
    assign exu_rs1_o  = rs1_q;
    assign exu_rs2_o  = rs2_q;
    assign exu_pc_o   = pc_q;
    assign exu_imme_o = imme_q;
    assign mc_start_o = mc_start_q;
    assign mc_kill_o  = mc_kill_q;
    assign wb_valid_o = wb_valid_q;
    assign wb_data_o  = wb_data_q;
    assign wb_rd_o    = rd_q;
    assign err_o      = err_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_exu_seq.sv
// Directed bench for exu_seq: a small adder stands in for the EXU, the multi-cycle unit
// is driven by hand, and every check is an immediate assertion against a fixed value.
module tb_exu_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [5:0]  id_ctrl_i;
    logic        id_mc_i;
    logic [63:0] id_rs1_i, id_rs2_i, id_pc_i, id_imme_i;
    logic [4:0]  id_rd_i;
    logic [5:0]  exu_ctrl_o;
    logic [63:0] exu_rs1_o, exu_rs2_o, exu_pc_o, exu_imme_o;
    logic [63:0] alu_result_i;
    logic        mc_start_o, mc_kill_o, mc_done_i;
    logic [63:0] mc_result_i;
    logic        wb_valid_o, wb_ready_i;
    logic [63:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        err_o;
    logic [31:0] retired_o;

    int n_assert = 0;
    int n_fail   = 0;
    int starts;

    always #5 clk_i = ~clk_i;

    // Bench EXU: jal -> pc+4, else (auipc ? pc : rs1) + (alusel2 ? imm : rs2)
    assign alu_result_i = exu_ctrl_o[2] ? exu_pc_o + 64'd4 :
                          (exu_ctrl_o[0] ? exu_pc_o : exu_rs1_o) +
                          (exu_ctrl_o[3] ? exu_imme_o : exu_rs2_o);

    exu_seq dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_ctrl_i(id_ctrl_i),
        .id_mc_i(id_mc_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_pc_i(id_pc_i),
        .id_imme_i(id_imme_i), .id_rd_i(id_rd_i), .exu_ctrl_o(exu_ctrl_o),
        .exu_rs1_o(exu_rs1_o), .exu_rs2_o(exu_rs2_o), .exu_pc_o(exu_pc_o),
        .exu_imme_o(exu_imme_o), .alu_result_i(alu_result_i), .mc_start_o(mc_start_o),
        .mc_kill_o(mc_kill_o), .mc_done_i(mc_done_i), .mc_result_i(mc_result_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_rd_o(wb_rd_o), .err_o(err_o), .retired_o(retired_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] ctrl, input logic mc, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [4:0] rd);
        id_valid_i = 1'b1;
        id_ctrl_i  = ctrl;
        id_mc_i    = mc;
        id_rs1_i   = rs1;
        id_rs2_i   = rs2;
        id_pc_i    = pc;
        id_imme_i  = imm;
        id_rd_i    = rd;
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0; id_ctrl_i = '0; id_mc_i = 1'b0;
        id_rs1_i = '0; id_rs2_i = '0; id_pc_i = '0; id_imme_i = '0; id_rd_i = '0;
        mc_done_i = 1'b0; mc_result_i = '0; wb_ready_i = 1'b0;
        tick(); tick();
        rst_n_i = 1'b1;
        tick();
        chk("rst_id_ready", 64'(id_ready_o), 64'd1);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_retired", 64'(retired_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);

        // Reset asserted in the middle of a multi-cycle op
        issue(6'b110000, 1'b1, 64'd55, 64'd1, 64'd0, 64'd0, 5'd9);
        tick();
        chk("mid_mc_start", 64'(mc_start_o), 64'd1);
        id_valid_i = 1'b0; id_mc_i = 1'b0;
        tick(); tick();
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_id_ready", 64'(id_ready_o), 64'd1);
        chk("arst_mc_start", 64'(mc_start_o), 64'd0);
        chk("arst_mc_kill", 64'(mc_kill_o), 64'd0);
        chk("arst_exu_rs1", exu_rs1_o, 64'd0);
        chk("arst_wb_rd", 64'(wb_rd_o), 64'd0);
        rst_n_i = 1'b1;
        tick();
        chk("arst_err", 64'(err_o), 64'd0);
        chk("arst_mc_kill_after", 64'(mc_kill_o), 64'd0);

        // ADDI x3 = 5 + 7, writeback stalled for 3 cycles
        issue(6'b101000, 1'b0, 64'd5, 64'd100, 64'h40, 64'd7, 5'd3);
        tick();
        chk("addi_exec_valid", 64'(wb_valid_o), 64'd0);
        chk("addi_exec_ready", 64'(id_ready_o), 64'd0);
        chk("addi_exec_ctrl", 64'(exu_ctrl_o), 64'h28);
        id_valid_i = 1'b0; id_rs1_i = 64'hDEAD;
        tick();
        chk("addi_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("addi_wb_data", wb_data_o, 64'd12);
        chk("addi_wb_rd", 64'(wb_rd_o), 64'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("addi_hold_data", wb_data_o, 64'd12);
            chk("addi_hold_valid", 64'(wb_valid_o), 64'd1);
        end
        wb_ready_i = 1'b1;
        #1;
        chk("addi_ready_wb", 64'(id_ready_o), 64'd1);
        tick();
        chk("addi_done_valid", 64'(wb_valid_o), 64'd0);
        chk("addi_retired", 64'(retired_o), 64'd1);
        wb_ready_i = 1'b0;

        // JAL followed back-to-back by ADD x2 = 3 + 4
        issue(6'b000100, 1'b0, 64'd0, 64'd0, 64'h1000, 64'd0, 5'd1);
        tick();
        chk("jal_exec_ctrl", 64'(exu_ctrl_o), 64'h04);
        chk("jal_exec_pc", exu_pc_o, 64'h1000);
        issue(6'b110000, 1'b0, 64'd3, 64'd4, 64'h2000, 64'd99, 5'd2);
        wb_ready_i = 1'b1;
        tick();
        chk("jal_wb_data", wb_data_o, 64'h1004);
        chk("jal_wb_rd", 64'(wb_rd_o), 64'd1);
        chk("jal_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("b2b_id_ready", 64'(id_ready_o), 64'd1);
        tick();
        chk("b2b_retired", 64'(retired_o), 64'd2);
        chk("b2b_ctrl", 64'(exu_ctrl_o), 64'h30);
        id_valid_i = 1'b0;
        tick();
        chk("add_wb_data", wb_data_o, 64'd7);
        chk("add_wb_rd", 64'(wb_rd_o), 64'd2);
        tick();
        chk("add_retired", 64'(retired_o), 64'd3);
        chk("add_done_valid", 64'(wb_valid_o), 64'd0);
        wb_ready_i = 1'b0;

        // DIV completing in its 10th MC cycle
        issue(6'b110000, 1'b1, 64'd84, 64'd2, 64'd0, 64'd0, 5'd4);
        tick();
        chk("div_start", 64'(mc_start_o), 64'd1);
        id_valid_i = 1'b0; id_mc_i = 1'b0;
        starts = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (mc_start_o) starts++;
        end
        chk("div_valid_before_done", 64'(wb_valid_o), 64'd0);
        mc_done_i = 1'b1; mc_result_i = 64'h2A;
        tick();
        mc_done_i = 1'b0; mc_result_i = 64'h0;
        chk("div_extra_starts", 64'(starts), 64'd0);
        chk("div_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("div_wb_data", wb_data_o, 64'h2A);
        chk("div_wb_rd", 64'(wb_rd_o), 64'd4);
        chk("div_err", 64'(err_o), 64'd0);
        wb_ready_i = 1'b1;
        tick();
        chk("div_retired", 64'(retired_o), 64'd4);
        wb_ready_i = 1'b0;

        // Multi-cycle op that never completes: timeout after 80 MC cycles
        issue(6'b110000, 1'b1, 64'd1, 64'd0, 64'd0, 64'd0, 5'd5);
        tick();
        id_valid_i = 1'b0; id_mc_i = 1'b0;
        for (int i = 0; i < 79; i++) tick();
        chk("to_80th_valid", 64'(wb_valid_o), 64'd0);
        chk("to_80th_err", 64'(err_o), 64'd0);
        chk("to_80th_kill", 64'(mc_kill_o), 64'd0);
        tick();
        chk("to_err", 64'(err_o), 64'd1);
        chk("to_kill", 64'(mc_kill_o), 64'd1);
        chk("to_wb_data", wb_data_o, 64'd0);
        chk("to_wb_valid", 64'(wb_valid_o), 64'd1);
        tick();
        chk("to_kill_pulse", 64'(mc_kill_o), 64'd0);
        chk("to_err_sticky", 64'(err_o), 64'd1);
        wb_ready_i = 1'b1;
        tick();
        chk("to_retired", 64'(retired_o), 64'd5);
        wb_ready_i = 1'b0;

        // Flush on the 3rd MC cycle with a new op presented
        issue(6'b110000, 1'b1, 64'hAA, 64'd0, 64'd0, 64'd0, 5'd6);
        tick();
        id_valid_i = 1'b0; id_mc_i = 1'b0;
        tick(); tick();
        flush_i = 1'b1;
        issue(6'b101000, 1'b0, 64'hBB, 64'd0, 64'd0, 64'd1, 5'd7);
        tick();
        chk("fl_kill", 64'(mc_kill_o), 64'd1);
        chk("fl_idle_ready", 64'(id_ready_o), 64'd1);
        chk("fl_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("fl_rs1_kept", exu_rs1_o, 64'hAA);
        chk("fl_rd_kept", 64'(wb_rd_o), 64'd6);
        flush_i = 1'b0; id_valid_i = 1'b0;
        tick();
        chk("fl_kill_pulse", 64'(mc_kill_o), 64'd0);
        mc_done_i = 1'b1; mc_result_i = 64'h55;
        tick();
        mc_done_i = 1'b0; mc_result_i = 64'h0;
        chk("late_done_valid", 64'(wb_valid_o), 64'd0);
        chk("late_done_data", wb_data_o, 64'd0);
        chk("late_done_retired", 64'(retired_o), 64'd5);
        tick();
        chk("late_done_valid2", 64'(wb_valid_o), 64'd0);
        chk("late_err_sticky", 64'(err_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
